// File: rtl/dot_product_sequencer.sv
// Serial dot-product sequencer: walks N_ELEM weight/pixel pairs through one shared
// multiplier and one shared adder, accumulating into acc and reporting a sign-extended sum.
module dot_product_sequencer #(
  parameter int N_ELEM  = 10,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1,
  parameter int DATA_W  = 10,
  parameter int COEF_W  = 19,
  parameter int ACC_W   = 26
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic                     start,
  output logic [3:0]               elem_idx,
  input  logic signed [COEF_W-1:0] wgt_sel,
  input  logic [DATA_W-1:0]        pix_sel,
  output logic signed [COEF_W-1:0] mul_wgt,
  output logic [DATA_W-1:0]        mul_pix,
  input  logic signed [ACC_W-1:0]  mul_result,
  output logic signed [ACC_W-1:0]  add_a,
  output logic signed [ACC_W-1:0]  add_b,
  input  logic signed [ACC_W-1:0]  add_result,
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W:0]    value
);

  localparam int LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);
  localparam logic [3:0]       LAST_IDX = 4'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_CNT  = CNT_W'(ADD_LAT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MUL, ADD, WAIT_ADD, DONE} state_t;

  function automatic logic signed [ACC_W:0] sext_acc(input logic signed [ACC_W-1:0] a);
    return {a[ACC_W-1], a};
  endfunction

  state_t                    state, state_nxt;
  logic [3:0]                k, k_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic signed [COEF_W-1:0]  mul_wgt_nxt;
  logic [DATA_W-1:0]         mul_pix_nxt;
  logic signed [ACC_W-1:0]   add_a_nxt, add_b_nxt;
  logic                      busy_nxt, done_nxt;
  logic signed [ACC_W:0]     value_nxt;

  // elem_idx tracks k, so it holds the last issued index outside ISSUE
  assign elem_idx = k;

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    mul_wgt_nxt = mul_wgt;
    mul_pix_nxt = mul_pix;
    add_a_nxt   = add_a;
    add_b_nxt   = add_b;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    value_nxt   = value;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          k_nxt     = '0;
          busy_nxt  = 1'b1;
          value_nxt = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_wgt_nxt = wgt_sel;
        mul_pix_nxt = pix_sel;
        cnt_nxt     = MUL_CNT;
        state_nxt   = WAIT_MUL;
      end
      WAIT_MUL: begin
        if (cnt == '0) state_nxt = ADD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ADD: begin
        add_a_nxt = mul_result;
        add_b_nxt = acc;
        cnt_nxt   = ADD_CNT;
        state_nxt = WAIT_ADD;
      end
      WAIT_ADD: begin
        if (cnt == '0) begin
          acc_nxt = add_result;
          if (k == LAST_IDX) begin
            // done and value are registered so both appear in the DONE cycle
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            value_nxt = sext_acc(add_result);
            state_nxt = DONE;
          end else begin
            k_nxt     = k + 4'd1;
            state_nxt = ISSUE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state   <= IDLE;
      k       <= '0;
      cnt     <= '0;
      acc     <= '0;
      mul_wgt <= '0;
      mul_pix <= '0;
      add_a   <= '0;
      add_b   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      value   <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      mul_wgt <= mul_wgt_nxt;
      mul_pix <= mul_pix_nxt;
      add_a   <= add_a_nxt;
      add_b   <= add_b_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      value   <= value_nxt;
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: two instances (default latencies and MUL_LAT=3/ADD_LAT=2)
// driven through integer multiplier/adder models and checked against a summed reference.
module tb_dot_product_sequencer;

  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  logic [18:0] wgt_mem [16];
  logic [9:0]  pix_mem [16];
  bit          neg_mode = 1'b0;

  // instance A: default latencies
  logic        rst_a, start_a, busy_a, done_a;
  logic [3:0]  elem_idx_a;
  logic [18:0] wgt_sel_a, mul_wgt_a;
  logic [9:0]  pix_sel_a, mul_pix_a;
  logic [25:0] mul_result_a, add_a_a, add_b_a, add_result_a, mul_q_a;
  logic [26:0] value_a;

  // instance B: MUL_LAT=3, ADD_LAT=2
  logic        rst_b, start_b, busy_b, done_b;
  logic [3:0]  elem_idx_b;
  logic [18:0] wgt_sel_b, mul_wgt_b;
  logic [9:0]  pix_sel_b, mul_pix_b;
  logic [25:0] mul_result_b, add_a_b, add_b_b, add_result_b;
  logic [25:0] mul_q1_b, mul_q2_b, mul_q3_b, add_q_b;
  logic [26:0] value_b;

  function automatic logic [25:0] mul_model(input logic signed [18:0] w, input logic [9:0] p,
                                            input bit neg);
    int prod;
    logic [31:0] pv;
    if (neg) return 26'h3FFFFFB;
    prod = int'(w) * int'(p);
    pv = prod;
    return pv[25:0];
  endfunction

  function automatic logic [26:0] ref_dot();
    logic [25:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + mul_model(wgt_mem[i], pix_mem[i], neg_mode);
    return {s[25], s};
  endfunction

  assign wgt_sel_a    = wgt_mem[elem_idx_a];
  assign pix_sel_a    = pix_mem[elem_idx_a];
  assign mul_result_a = mul_q_a;
  assign add_result_a = add_a_a + add_b_a;
  always @(posedge clk) mul_q_a <= mul_model(mul_wgt_a, mul_pix_a, neg_mode);

  assign wgt_sel_b    = wgt_mem[elem_idx_b];
  assign pix_sel_b    = pix_mem[elem_idx_b];
  assign mul_result_b = mul_q3_b;
  assign add_result_b = add_q_b;
  always @(posedge clk) begin
    mul_q1_b <= mul_model(mul_wgt_b, mul_pix_b, neg_mode);
    mul_q2_b <= mul_q1_b;
    mul_q3_b <= mul_q2_b;
    add_q_b  <= add_a_b + add_b_b;
  end

  dot_product_sequencer u_dut_a (
    .clk(clk), .GlobalReset(rst_a), .start(start_a), .elem_idx(elem_idx_a),
    .wgt_sel(wgt_sel_a), .pix_sel(pix_sel_a), .mul_wgt(mul_wgt_a), .mul_pix(mul_pix_a),
    .mul_result(mul_result_a), .add_a(add_a_a), .add_b(add_b_a), .add_result(add_result_a),
    .busy(busy_a), .done(done_a), .value(value_a)
  );

  dot_product_sequencer #(.MUL_LAT(3), .ADD_LAT(2)) u_dut_b (
    .clk(clk), .GlobalReset(rst_b), .start(start_b), .elem_idx(elem_idx_b),
    .wgt_sel(wgt_sel_b), .pix_sel(pix_sel_b), .mul_wgt(mul_wgt_b), .mul_pix(mul_pix_b),
    .mul_result(mul_result_b), .add_a(add_a_b), .add_b(add_b_b), .add_result(add_result_b),
    .busy(busy_b), .done(done_b), .value(value_b)
  );

  logic        sel = 1'b0;
  logic        s_busy, s_done;
  logic [3:0]  s_idx;
  logic [18:0] s_mwgt;
  logic [9:0]  s_mpix;
  logic [26:0] s_value;
  assign s_busy  = sel ? busy_b     : busy_a;
  assign s_done  = sel ? done_b     : done_a;
  assign s_idx   = sel ? elem_idx_b : elem_idx_a;
  assign s_mwgt  = sel ? mul_wgt_b  : mul_wgt_a;
  assign s_mpix  = sel ? mul_pix_b  : mul_pix_a;
  assign s_value = sel ? value_b    : value_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else            start_b = v;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_idx"},   elem_idx_a, 0);
    check({tag, "_mwgt"},  mul_wgt_a, 0);
    check({tag, "_mpix"},  mul_pix_a, 0);
    check({tag, "_adda"},  add_a_a, 0);
    check({tag, "_addb"},  add_b_a, 0);
    check({tag, "_busy"},  busy_a, 0);
    check({tag, "_done"},  done_a, 0);
    check({tag, "_value"}, value_a, 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      wgt_mem[i] = 19'(i + 1);
      pix_mem[i] = 10'd2;
    end
  endtask

  task automatic load_const(input logic [18:0] w, input logic [9:0] p);
    for (int i = 0; i < 16; i++) begin
      wgt_mem[i] = w;
      pix_mem[i] = p;
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) begin
      wgt_mem[i] = 19'($urandom);
      pix_mem[i] = 10'($urandom);
    end
  endtask

  // One full computation: expected timing comes from the per-term cycle cost,
  // with a stray start mid-run and another during DONE, both of which must be dropped.
  task automatic run(input int which, input string tag);
    int per, mlat, expc, term, off;
    logic [26:0] expv;
    sel  = (which != 0);
    mlat = (which != 0) ? 3 : 1;
    per  = (which != 0) ? 7 : 4;
    expc = N * per + 1;
    expv = ref_dot();
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    for (int c = 1; c <= expc + 2; c++) begin
      term = (c - 1) / per;
      off  = (c - 1) % per;
      if (term > N - 1) term = N - 1;
      check({tag, "_done"}, s_done, (c == expc));
      check({tag, "_busy"}, s_busy, (c < expc));
      check({tag, "_idx"},  s_idx, term);
      if (c == 1) check({tag, "_value_clr"}, s_value, 0);
      if (c >= expc) check({tag, "_value"}, s_value, expv);
      if (c < expc && off >= 1 && off <= mlat) begin
        check({tag, "_mwgt"}, s_mwgt, wgt_mem[term]);
        check({tag, "_mpix"}, s_mpix, pix_mem[term]);
      end
      if (c == 10 || c == expc)          set_start(which, 1'b1);
      if (c == 11 || c == expc + 1)      set_start(which, 1'b0);
      @(posedge clk); #1;
    end
    set_start(which, 1'b0);
  endtask

  initial begin
    int ndone;
    int ph;
    logic [26:0] expv;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    load_ramp();
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("rst_a");
    check("rst_b_busy", busy_b, 0);
    check("rst_b_value", value_b, 0);
    check("rst_b_idx", elem_idx_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    load_ramp();                 run(0, "ramp");
    load_const(19'd1, 10'h3FF);  run(0, "allmax");
    load_const(19'd1, 10'h000);  run(0, "allzero");
    neg_mode = 1'b1;             run(0, "neg");
    neg_mode = 1'b0;
    load_rand();                 run(0, "rand_a0");
    load_rand();                 run(0, "rand_a1");
    load_ramp();                 run(1, "lat_ramp");
    load_rand();                 run(1, "lat_rand");

    // abort during WAIT_ADD of term 5 (cycle 24 with default latencies)
    sel = 1'b0;
    load_rand();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c < 24; c++) begin
      @(posedge clk); #1;
    end
    check("abort_busy_pre", busy_a, 1);
    check("abort_idx_pre", elem_idx_a, 5);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check_zero_a("abort");
    load_rand();                 run(0, "after_abort");

    // start held high: back-to-back runs separated by DONE plus one IDLE cycle
    load_ramp();
    expv = ref_dot();
    ndone = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 100; c++) begin
      ph = c % 42;
      check("b2b_done", done_a, (ph == 41));
      check("b2b_busy", busy_a, (ph >= 1 && ph <= 40));
      if (done_a) begin
        ndone++;
        check("b2b_value", value_a, expv);
      end
      if (c == 43) check("b2b_value_clr", value_a, 0);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("b2b_count", ndone, 2);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check_zero_a("final_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
